// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle ALU: width defaults, opcodes, FSM states.
// No logic; constants only.
// Opcode constants are 32-bit and are cast to the opcode width at the point of use.
package alu_multicycle_pkg;

    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_OPRN_WIDTH = 6;

    localparam int unsigned ALU_OPRN_ADD  = 32'h01;
    localparam int unsigned ALU_OPRN_SUB  = 32'h02;
    localparam int unsigned ALU_OPRN_MUL  = 32'h03;
    localparam int unsigned ALU_OPRN_SHR  = 32'h04;
    localparam int unsigned ALU_OPRN_SHL  = 32'h05;
    localparam int unsigned ALU_OPRN_AND  = 32'h06;
    localparam int unsigned ALU_OPRN_OR   = 32'h07;
    localparam int unsigned ALU_OPRN_NOR  = 32'h08;
    localparam int unsigned ALU_OPRN_SLTU = 32'h09;
    localparam int unsigned ALU_OPRN_SLTS = 32'h0A;

    // IDLE accepts requests; MUL while the shift-add unit iterates.
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the register-read stage and the ALU.
// START/OPRN/OP1/OP2 flow towards the ALU; BUSY/DONE/results flow back.
// BUSY high means START is ignored (not queued).
interface alu_multicycle_if
    import alu_multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int OPRN_WIDTH = ALU_OPRN_WIDTH
);
    logic                  START;
    logic [OPRN_WIDTH-1:0] OPRN;
    logic [DATA_WIDTH-1:0] OP1;
    logic [DATA_WIDTH-1:0] OP2;
    logic                  BUSY;
    logic                  DONE;
    logic [DATA_WIDTH-1:0] OUT;
    logic [DATA_WIDTH-1:0] OUT_HI;
    logic                  ZERO;
    logic                  ERR;

    modport master (
        output START, OPRN, OP1, OP2,
        input  BUSY, DONE, OUT, OUT_HI, ZERO, ERR
    );

    modport slave (
        input  START, OPRN, OP1, OP2,
        output BUSY, DONE, OUT, OUT_HI, ZERO, ERR
    );

endinterface

// File: rtl/alu_multicycle_mul_iter.sv
// Shift-add unsigned multiplier retiring MUL_BITS multiplier bits per cycle.
// Latency: DATA_WIDTH/MUL_BITS cycles after LOAD; 'product' is the next-step value, valid when 'last'.
// No backpressure; LOAD restarts the iteration unconditionally.
module alu_mul_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_BITS   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    LOAD,
    input  logic [DATA_WIDTH-1:0]   multiplicand,
    input  logic [DATA_WIDTH-1:0]   multiplier,
    output logic [2*DATA_WIDTH-1:0] product,
    output logic                    last
);
    localparam int N     = DATA_WIDTH / MUL_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [DATA_WIDTH-1:0]          mcand_q;
    // Upper half accumulates partial sums; lower half starts as the multiplier
    // and is consumed from the bottom as the accumulator shifts right.
    logic [2*DATA_WIDTH-1:0]        acc_q;
    logic [2*DATA_WIDTH-1:0]        acc_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [DATA_WIDTH+MUL_BITS-1:0] partial;
    logic [DATA_WIDTH+MUL_BITS-1:0] sum;

    // One step: add multiplicand times the low multiplier chunk into the upper half.
    // The sum cannot exceed (2^W-1)*2^M, so W+M bits never overflow.
    always_comb begin
        partial = {{MUL_BITS{1'b0}}, mcand_q} * {{DATA_WIDTH{1'b0}}, acc_q[MUL_BITS-1:0]};
        sum     = {{MUL_BITS{1'b0}}, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + partial;
    end

    // Shift right by one chunk; when a single chunk covers the whole word the sum is the product.
    generate
        if (MUL_BITS < DATA_WIDTH) begin : g_shift
            assign acc_d = {sum, acc_q[DATA_WIDTH-1:MUL_BITS]};
        end else begin : g_whole
            assign acc_d = sum;
        end
    endgenerate

    assign product = acc_d;
    assign last    = (cnt_q == CNT_W'(N - 1));

    // Accumulator and iteration counter; free-runs outside a multiply, only read while in MUL.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (LOAD) begin
            mcand_q <= multiplicand;
            acc_q   <= {{DATA_WIDTH{1'b0}}, multiplier};
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops plus an iterative double-width multiply.
// Latency: single-cycle ops report at the START edge; multiply reports DATA_WIDTH/MUL_BITS edges later.
// Backpressure: BUSY high during multiply; START is dropped (not queued) while BUSY.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int OPRN_WIDTH = ALU_OPRN_WIDTH,
    parameter int MUL_BITS   = 1
) (
    input  logic            CLK,
    input  logic            RST,
    alu_multicycle_if.slave bus
);
    alu_state_e              state_q;
    logic [DATA_WIDTH-1:0]   out_q;
    logic [DATA_WIDTH-1:0]   out_hi_q;
    logic                    zero_q;
    logic                    done_q;
    logic                    err_q;
    logic                    busy_q;

    logic [DATA_WIDTH-1:0]   res_d;
    logic                    err_d;
    logic                    is_mul;
    logic                    mul_load;
    logic [2*DATA_WIDTH-1:0] mul_prod;
    logic                    mul_last;

    assign is_mul   = (bus.OPRN == OPRN_WIDTH'(ALU_OPRN_MUL));
    assign mul_load = (state_q == IDLE) && bus.START && is_mul;

    alu_mul_iter #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUL_BITS   (MUL_BITS)
    ) u_mul (
        .CLK          (CLK),
        .RST          (RST),
        .LOAD         (mul_load),
        .multiplicand (bus.OP1),
        .multiplier   (bus.OP2),
        .product      (mul_prod),
        .last         (mul_last)
    );

    // Single-cycle result from the live operands; unknown opcodes give 0 with an error flag.
    // Shifts use the full OP2 value, so amounts >= DATA_WIDTH naturally yield 0.
    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        case (bus.OPRN)
            OPRN_WIDTH'(ALU_OPRN_ADD):  res_d = bus.OP1 + bus.OP2;
            OPRN_WIDTH'(ALU_OPRN_SUB):  res_d = bus.OP1 - bus.OP2;
            OPRN_WIDTH'(ALU_OPRN_MUL):  res_d = '0;
            OPRN_WIDTH'(ALU_OPRN_SHR):  res_d = bus.OP1 >> bus.OP2;
            OPRN_WIDTH'(ALU_OPRN_SHL):  res_d = bus.OP1 << bus.OP2;
            OPRN_WIDTH'(ALU_OPRN_AND):  res_d = bus.OP1 & bus.OP2;
            OPRN_WIDTH'(ALU_OPRN_OR):   res_d = bus.OP1 | bus.OP2;
            OPRN_WIDTH'(ALU_OPRN_NOR):  res_d = ~(bus.OP1 | bus.OP2);
            OPRN_WIDTH'(ALU_OPRN_SLTU): res_d = {{(DATA_WIDTH-1){1'b0}}, (bus.OP1 < bus.OP2)};
            OPRN_WIDTH'(ALU_OPRN_SLTS): res_d = {{(DATA_WIDTH-1){1'b0}},
                                                 ($signed(bus.OP1) < $signed(bus.OP2))};
            default:                    err_d = 1'b1;
        endcase
    end

    // Control FSM with registered results; DONE/ERR default low so they pulse for one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            out_q    <= '0;
            out_hi_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        if (is_mul) begin
                            state_q <= MUL;
                            busy_q  <= 1'b1;
                        end else begin
                            out_q    <= res_d;
                            out_hi_q <= '0;
                            zero_q   <= (res_d == '0);
                            done_q   <= 1'b1;
                            err_q    <= err_d;
                        end
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        out_q    <= mul_prod[DATA_WIDTH-1:0];
                        out_hi_q <= mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
                        zero_q   <= (mul_prod[DATA_WIDTH-1:0] == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.OUT    = out_q;
    assign bus.OUT_HI = out_hi_q;
    assign bus.ZERO   = zero_q;
    assign bus.DONE   = done_q;
    assign bus.ERR    = err_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle with a result scoreboard.
// Two instances: MUL_BITS=1 (main) and MUL_BITS=4 (multiply throughput).
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    localparam int W  = 32;
    localparam int N1 = 32;
    localparam int N4 = 8;

    typedef struct {
        string        tag;
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         zero;
        logic         err;
        int           busy;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_run = 0;
    exp_t q1[$];
    exp_t q4[$];

    alu_multicycle_if #(.DATA_WIDTH(W), .OPRN_WIDTH(6)) bus1 ();
    alu_multicycle_if #(.DATA_WIDTH(W), .OPRN_WIDTH(6)) bus4 ();

    alu_multicycle #(.DATA_WIDTH(W), .OPRN_WIDTH(6), .MUL_BITS(1)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bus1.slave)
    );

    alu_multicycle #(.DATA_WIDTH(W), .OPRN_WIDTH(6), .MUL_BITS(4)) dut4 (
        .CLK (clk),
        .RST (rst),
        .bus (bus4.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for dut1: every DONE must match the oldest pending expectation.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (bus1.BUSY === 1'b1) busy_run++;
            if (bus1.DONE === 1'b1) begin
                tests++;
                assert (q1.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_done: observed DONE=1 at cycle %0d, required no pending result", cyc);
                end
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check({e.tag, ".out"},  bus1.OUT,    e.out);
                    check({e.tag, ".hi"},   bus1.OUT_HI, e.hi);
                    check({e.tag, ".zero"}, bus1.ZERO,   e.zero);
                    check({e.tag, ".err"},  bus1.ERR,    e.err);
                    check({e.tag, ".cyc"},  cyc,         e.cyc);
                    check({e.tag, ".busy"}, busy_run,    e.busy);
                end
                busy_run = 0;
            end
        end
    end

    // Drive one request at a negedge and record its expected result.
    task automatic issue(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eo, input logic [W-1:0] eh,
                         input logic ee);
        exp_t e;
        e.tag  = tag;
        e.out  = eo;
        e.hi   = eh;
        e.zero = (eo == '0);
        e.err  = ee;
        e.busy = (op == 6'h03) ? N1 : 0;
        e.cyc  = cyc + 1 + e.busy;
        q1.push_back(e);
        bus1.START = 1'b1;
        bus1.OPRN  = op;
        bus1.OP1   = a;
        bus1.OP2   = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus1.START = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus1.START = 1'b0;
        while (q1.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        assert (q1.size() == 0) else begin
            fails++;
            $error("FAIL %s.timeout: observed %0d results pending, required 0", tag, q1.size());
            q1.delete();
        end
    endtask

    task automatic check_rst(input string tag, input logic [W-1:0] o, input logic [W-1:0] h,
                             input logic z, input logic b, input logic d, input logic e);
        check({tag, ".out"},  o, '0);
        check({tag, ".hi"},   h, '0);
        check({tag, ".zero"}, z, 1'b1);
        check({tag, ".busy"}, b, 1'b0);
        check({tag, ".done"}, d, 1'b0);
        check({tag, ".err"},  e, 1'b0);
    endtask

    initial begin
        exp_t e4;
        int   b4;
        bit   got;

        bus1.START = 1'b0; bus1.OPRN = '0; bus1.OP1 = '0; bus1.OP2 = '0;
        bus4.START = 1'b0; bus4.OPRN = '0; bus4.OP1 = '0; bus4.OP2 = '0;

        // Reset for two cycles, then check idle outputs.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_rst("reset1", bus1.OUT, bus1.OUT_HI, bus1.ZERO, bus1.BUSY, bus1.DONE, bus1.ERR);
        check_rst("reset4", bus4.OUT, bus4.OUT_HI, bus4.ZERO, bus4.BUSY, bus4.DONE, bus4.ERR);

        // Single-cycle ops back to back.
        issue("add",     6'(ALU_OPRN_ADD), 32'd15, 32'd3,  32'd18,        '0, 1'b0);
        issue("sub",     6'(ALU_OPRN_SUB), 32'd15, 32'd5,  32'd10,        '0, 1'b0);
        issue("sub_neg", 6'(ALU_OPRN_SUB), 32'd3,  32'd5,  32'hFFFFFFFE,  '0, 1'b0);
        issue("shr",     6'(ALU_OPRN_SHR), 32'd7,  32'd2,  32'd1,         '0, 1'b0);
        issue("shl",     6'(ALU_OPRN_SHL), 32'd7,  32'd3,  32'd56,        '0, 1'b0);
        issue("shl_40",  6'(ALU_OPRN_SHL), 32'd1,  32'd40, 32'd0,         '0, 1'b0);
        issue("shr_31",  6'(ALU_OPRN_SHR), 32'h80000000, 32'd31, 32'd1,   '0, 1'b0);
        issue("shr_32",  6'(ALU_OPRN_SHR), 32'hFFFFFFFF, 32'd32, 32'd0,   '0, 1'b0);
        issue("and",     6'(ALU_OPRN_AND), 32'd15, 32'd5,  32'd5,         '0, 1'b0);
        issue("or",      6'(ALU_OPRN_OR),  32'd15, 32'd5,  32'd15,        '0, 1'b0);
        issue("nor",     6'(ALU_OPRN_NOR), 32'd15, 32'd5,  32'hFFFFFFF0,  '0, 1'b0);
        drain("single");

        // Compares.
        issue("sltu_big",  6'(ALU_OPRN_SLTU), 32'hFFFFFFFF, 32'd1, 32'd0, '0, 1'b0);
        issue("slts_neg",  6'(ALU_OPRN_SLTS), 32'hFFFFFFFF, 32'd1, 32'd1, '0, 1'b0);
        issue("sltu_lt",   6'(ALU_OPRN_SLTU), 32'd1, 32'd2, 32'd1,         '0, 1'b0);
        issue("sltu_ge",   6'(ALU_OPRN_SLTU), 32'd2, 32'd1, 32'd0,         '0, 1'b0);
        issue("slts_pos",  6'(ALU_OPRN_SLTS), 32'd1, 32'h80000000, 32'd0, '0, 1'b0);
        drain("compare");

        // Multiply, MUL_BITS=1; the second one starts in the DONE cycle of the first.
        issue("mul_2x5", 6'(ALU_OPRN_MUL), 32'd2, 32'd5, 32'd10, 32'd0, 1'b0);
        drain("mul_2x5");
        issue("mul_max", 6'(ALU_OPRN_MUL), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b0);
        idle(5);
        // Stray request mid-multiply must be dropped.
        bus1.START = 1'b1; bus1.OPRN = 6'(ALU_OPRN_ADD); bus1.OP1 = 32'd1; bus1.OP2 = 32'd1;
        @(negedge clk);
        drain("mul_max");
        issue("mul_zero", 6'(ALU_OPRN_MUL), 32'd4, 32'd0, 32'd0, 32'd0, 1'b0);
        drain("mul_zero");
        issue("mul_big", 6'(ALU_OPRN_MUL), 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, 32'h0B00EA4E, 1'b0);
        drain("mul_big");
        idle(2);

        // Multiply, MUL_BITS=4.
        e4.tag = "mul4"; e4.out = 32'h23456780; e4.hi = 32'h1; e4.zero = 1'b0; e4.err = 1'b0;
        e4.busy = N4; e4.cyc = 0;
        q4.push_back(e4);
        bus4.START = 1'b1; bus4.OPRN = 6'(ALU_OPRN_MUL); bus4.OP1 = 32'h12345678; bus4.OP2 = 32'h10;
        b4  = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            bus4.START = 1'b0;
            if (bus4.BUSY === 1'b1) b4++;
            if (bus4.DONE === 1'b1) got = 1'b1;
        end
        check("mul4.done", got, 1'b1);
        if (got && q4.size() != 0) begin
            e4 = q4.pop_front();
            check("mul4.out",  bus4.OUT,    e4.out);
            check("mul4.hi",   bus4.OUT_HI, e4.hi);
            check("mul4.zero", bus4.ZERO,   e4.zero);
            check("mul4.busy", b4,          e4.busy);
        end
        @(negedge clk);

        // Invalid opcodes.
        issue("inv_00", 6'h00, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1);
        issue("inv_0b", 6'h0B, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1);
        issue("add_11", 6'(ALU_OPRN_ADD), 32'd1, 32'd1, 32'd2, 32'd0, 1'b0);
        drain("invalid");

        // Reset at iteration 10 of a multiply: no result, outputs back to reset values.
        bus1.START = 1'b1; bus1.OPRN = 6'(ALU_OPRN_MUL); bus1.OP1 = 32'd3; bus1.OP2 = 32'd3;
        @(negedge clk);
        bus1.START = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_rst("abort", bus1.OUT, bus1.OUT_HI, bus1.ZERO, bus1.BUSY, bus1.DONE, bus1.ERR);
        idle(40);

        issue("add_6_7", 6'(ALU_OPRN_ADD), 32'd6, 32'd7, 32'd13, 32'd0, 1'b0);
        drain("final");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
